// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, default sizes and address-wrap helper for mem_burst_ctrl.
package mem_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_MAX_BURST = 16;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
  // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input int unsigned depth);
    return (a == depth - 1) ? 32'd0 : a + 32'd1;
  endfunction
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: request, write-data and read-data channels of mem_burst_ctrl.
interface mem_burst_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 4
);
  logic                  valid_i, ready_o, wr_rd_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  wvalid_i, wready_o;
  logic [WIDTH-1:0]      wdata_i;
  logic [WIDTH/8-1:0]    wstrb_i;
  logic                  rvalid_o, rready_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  done_o;
  modport master (
    output valid_i, wr_rd_i, addr_i, len_i, wvalid_i, wdata_i, wstrb_i, rready_i,
    input  ready_o, wready_o, rvalid_o, rdata_o, done_o
  );
  modport slave (
    input  valid_i, wr_rd_i, addr_i, len_i, wvalid_i, wdata_i, wstrb_i, rready_i,
    output ready_o, wready_o, rvalid_o, rdata_o, done_o
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port storage with byte-enabled write and registered synchronous read.
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    be_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (wr_en_i)
      for (int k = 0; k < WIDTH/8; k++)
        if (be_i[k]) mem[wr_addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
    if (rd_en_i) rdata_q <= mem[rd_addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst controller over mem_array with valid/ready request, write and read channels.
// Define BYTE_STRB_EN to honour wstrb_i on write beats; otherwise full words are written.
module mem_burst_ctrl import mem_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_burst_ctrl_if.slave bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, nxt_addr, rd_addr;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic                  rd_en, wr_en, last;
  logic [WIDTH/8-1:0]    be;
  logic [WIDTH-1:0]      rd_data;
`ifdef BYTE_STRB_EN
  assign be = bus.wstrb_i;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.wstrb_i;
  assign be = '1;
`endif
  assign nxt_addr = ADDR_WIDTH'(next_addr(32'(cur_addr_q), DEPTH));
  assign last     = beats_left_q == '0;
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    rd_addr      = nxt_addr;
    case (state_q)
      IDLE: if (bus.valid_i) begin
        cur_addr_d   = bus.addr_i;
        beats_left_d = bus.len_i;
        state_d      = bus.wr_rd_i ? WRITE : READ;
        rd_en        = !bus.wr_rd_i;
        rd_addr      = bus.addr_i;
      end
      WRITE: if (bus.wvalid_i) begin
        wr_en        = 1'b1;
        state_d      = last ? DONE : WRITE;
        cur_addr_d   = nxt_addr;
        beats_left_d = beats_left_q - 1'b1;
      end
      READ: if (bus.rready_i) begin
        rd_en        = !last;
        state_d      = last ? DONE : READ;
        cur_addr_d   = nxt_addr;
        beats_left_d = beats_left_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
    end
  end
  assign bus.ready_o  = state_q == IDLE;
  assign bus.wready_o = state_q == WRITE;
  assign bus.rvalid_o = state_q == READ;
  assign bus.done_o   = state_q == DONE;
  assign bus.rdata_o  = (state_q == READ) ? rd_data : '0;
  mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (cur_addr_q),
    .wdata_i   (bus.wdata_i),
    .be_i      (be),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rdata_o   (rd_data)
  );
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bursts with hand-computed data for mem_burst_ctrl.
module tb_mem_burst_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [15:0] strb_exp;
  always #5 clk = ~clk;
  mem_burst_ctrl_if #(.WIDTH(16), .ADDR_WIDTH(6), .LEN_WIDTH(4)) bus ();
  mem_burst_ctrl dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, " ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, " wready"}, 32'(bus.wready_o), 32'd0);
    check({tag, " rvalid"}, 32'(bus.rvalid_o), 32'd0);
    check({tag, " rdata"}, 32'(bus.rdata_o), 32'd0);
    check({tag, " done"}, 32'(bus.done_o), 32'd0);
  endtask
  task automatic wr_burst(input logic [5:0] a, input logic [3:0] l, input logic [15:0] base, input int gap_beat);
    check("wr accept ready", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1; bus.wr_rd_i = 1'b1; bus.addr_i = a; bus.len_i = l;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      check("wr busy ready", 32'(bus.ready_o), 32'd0);
      check("wr wready", 32'(bus.wready_o), 32'd1);
      if (i == gap_beat) begin
        bus.wvalid_i = 1'b0; bus.wdata_i = 16'hDEAD;
        @(negedge clk);
        check("wr gap done", 32'(bus.done_o), 32'd0);
      end
      bus.wvalid_i = 1'b1; bus.wdata_i = base + 16'(i);
      @(negedge clk);
    end
    bus.wvalid_i = 1'b0;
    check("wr done pulse", 32'(bus.done_o), 32'd1);
    check("wr done ready", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    check("wr done drop", 32'(bus.done_o), 32'd0);
  endtask
  task automatic rd_burst(input logic [5:0] a, input logic [3:0] l, input logic [15:0] base, input int stall_beat);
    check("rd accept ready", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1; bus.wr_rd_i = 1'b0; bus.addr_i = a; bus.len_i = l; bus.rready_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      check("rd rvalid", 32'(bus.rvalid_o), 32'd1);
      check("rd ready low", 32'(bus.ready_o), 32'd0);
      check("rd data", 32'(bus.rdata_o), 32'(base + 16'(i)));
      if (i == stall_beat) begin
        bus.rready_i = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("rd stall rvalid", 32'(bus.rvalid_o), 32'd1);
          check("rd stall data", 32'(bus.rdata_o), 32'(base + 16'(i)));
        end
        bus.rready_i = 1'b1;
      end
      @(negedge clk);
    end
    bus.rready_i = 1'b0;
    check("rd done pulse", 32'(bus.done_o), 32'd1);
    check("rd rvalid drop", 32'(bus.rvalid_o), 32'd0);
    @(negedge clk);
    check("rd done drop", 32'(bus.done_o), 32'd0);
  endtask
  initial begin
    bus.valid_i = 1'b0; bus.wr_rd_i = 1'b0; bus.addr_i = '0; bus.len_i = '0;
    bus.wvalid_i = 1'b0; bus.wdata_i = '0; bus.wstrb_i = 2'b11; bus.rready_i = 1'b0;
    repeat (2) @(negedge clk);
    idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    idle_outputs("idle");
    wr_burst(6'd0, 4'd0, 16'hA5A5, -1);
    rd_burst(6'd0, 4'd0, 16'hA5A5, -1);
    wr_burst(6'd15, 4'd4, 16'd1, -1);
    rd_burst(6'd15, 4'd4, 16'd1, 1);
    wr_burst(6'd62, 4'd3, 16'd10, -1);
    rd_burst(6'd62, 4'd3, 16'd10, -1);
    rd_burst(6'd0, 4'd1, 16'd12, -1);
    wr_burst(6'd33, 4'd0, 16'h0077, -1);
    wr_burst(6'd30, 4'd2, 16'h0050, 1);
    rd_burst(6'd30, 4'd2, 16'h0050, -1);
    rd_burst(6'd33, 4'd0, 16'h0077, -1);
    // Abort a len-7 write while beat 2 is on the bus.
    bus.valid_i = 1'b1; bus.wr_rd_i = 1'b1; bus.addr_i = 6'd40; bus.len_i = 4'd7;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.wvalid_i = 1'b1; bus.wdata_i = 16'h0200;
    @(negedge clk);
    bus.wdata_i = 16'h0201;
    @(negedge clk);
    bus.wdata_i = 16'h0202;
    rst_n = 1'b0;
    #1;
    idle_outputs("async reset");
    bus.wvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_outputs("post reset");
    rd_burst(6'd40, 4'd1, 16'h0200, -1);
    wr_burst(6'd5, 4'd0, 16'h1234, -1);
    bus.wstrb_i = 2'b01;
    wr_burst(6'd5, 4'd0, 16'hABCD, -1);
    bus.wstrb_i = 2'b11;
`ifdef BYTE_STRB_EN
    strb_exp = 16'h12CD;
`else
    strb_exp = 16'hABCD;
`endif
    rd_burst(6'd5, 4'd0, strb_exp, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Parametrised single-port synchronous memory with a valid/ready request handshake and incrementing bursts of 1..MAX_BURST beats.
- Separate write-data and read-data channels; the read channel supports backpressure.
- Next-generation replacement for the team's single-beat valid/ready memory. Sits between a bus master (testbench or controller) and on-chip storage.

Parameters:
- WIDTH, 16, data word width in bits (multiple of 8)
- DEPTH, 64, number of words
- ADDR_WIDTH, $clog2(DEPTH), address width
- MAX_BURST, 16, maximum beats per burst
- LEN_WIDTH, $clog2(MAX_BURST), burst length field width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous active-low reset (0 = reset)
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- wr_rd_i  in  1  1 = write burst, 0 = read burst
- addr_i  in  ADDR_WIDTH  burst start address
- len_i  in  LEN_WIDTH  beats minus one (0 = 1 beat)
- wvalid_i  in  1  write beat valid
- wready_o  out  1  write beat accepted when wvalid_i && wready_o
- wdata_i  in  WIDTH  write data
- wstrb_i  in  WIDTH/8  byte enables (only used when BYTE_STRB_EN is defined)
- rvalid_o  out  1  read beat valid
- rready_i  in  1  read beat consumed when rvalid_o && rready_i
- rdata_o  out  WIDTH  read data
- done_o  out  1  one-cycle pulse after the last beat of any burst

Behaviour:
- Reset (rst_i=0, asynchronous): FSM goes to IDLE; ready_o=1, wready_o=0, rvalid_o=0, rdata_o=0, done_o=0; internal address and beat counters cleared. Memory contents are not cleared. Reset mid-burst abandons the burst with no done_o.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - ready_o=1, all other outputs 0.
  - On valid_i: latch cur_addr=addr_i and beats_left=len_i.
  - wr_rd_i=1 -> WRITE; wr_rd_i=0 -> READ, issuing the memory read of addr_i on the same edge.
- WRITE:
  - ready_o=0, wready_o=1.
  - Each edge with wvalid_i writes mem[cur_addr]<=wdata_i, then cur_addr increments and beats_left decrements.
  - A beat with beats_left==0 -> DONE.
  - wvalid_i low stalls; no state change.
- READ:
  - rvalid_o=1 and rdata_o=mem[cur_addr], registered: the first beat is valid one cycle after request acceptance.
  - Each edge with rready_i advances cur_addr and loads the next word, so back-to-back beats are possible.
  - rready_i low holds rdata_o and rvalid_o stable.
  - The handshake on the beat with beats_left==0 -> DONE; rvalid_o drops the next cycle.
- DONE: done_o=1 for exactly one cycle, ready_o=0, then -> IDLE.
- Request-to-request minimum spacing: burst beats + 2 cycles.
- Address wrap: cur_addr at DEPTH-1 increments to 0. This holds for non-power-of-two DEPTH as well (explicit compare, not modulo by width).
- len_i wider than remaining depth is legal; the burst wraps.
- While not in IDLE: valid_i is ignored, and wvalid_i outside WRITE / rready_i outside READ have no effect.
- Write and read never occur in the same cycle (single port).

Optional Feature:
- Macro: BYTE_STRB_EN.
- Defined: write beats update only bytes whose wstrb_i bit is 1. Byte k is wdata_i[8k+7:8k]; unselected bytes keep their old value.
- Undefined: wstrb_i is ignored and full words are always written. The port remains present for interface stability.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state enum (IDLE, WRITE, READ, DONE)
  - default WIDTH/DEPTH/MAX_BURST constants
  - a next_addr wrap function
- One natural sub-module: mem_array, the storage with a synchronous read port and a byte-enabled write port.
- The controller FSM and counters stay in mem_burst_ctrl.

Test Plan:
- Single write then read: write addr 0, len 0, data 16'hA5A5; read addr 0, len 0 -> rdata_o=16'hA5A5 one cycle after acceptance; done_o pulses once per burst.
- Burst: write addr 15, len 4, data 1..5; read back -> rdata_o 1,2,3,4,5 at addr 15..19; ready_o low throughout both bursts.
- Wrap: write addr 62, len 3, data 10..13 -> locations 62,63,0,1 hold 10,11,12,13 on readback.
- Backpressure/stall: read of the same burst with rready_i toggling 1,0,0,1 -> rdata_o held while stalled, no beat skipped or duplicated. Write with wvalid_i gaps -> only valid beats are written.
- Reset mid-burst: drop rst_i during beat 2 of a len 7 write -> outputs at reset values immediately, no done_o; the next request is accepted normally and beats 0-1 remain written.
- BYTE_STRB_EN: location 5 = 16'h1234; write 16'hABCD with wstrb 2'b01 -> reads 16'h12CD. Without the macro -> reads 16'hABCD.
